// File: rtl/music_pkg.sv
// Shared definitions for the music play controller and sibling panel modules:
// state encoding and the default timing constants derived from the system clock.
package music_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StPlay = ST_PLAY,
    StGap  = ST_GAP
  } music_state_e;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEBOUNCE_CYC_DEF = CLK_HZ / 50;     // 20 ms
  localparam int unsigned PLAY_CYC_DEF     = 1_000_000_000;   // 60 notes x ~1/3 s
  localparam int unsigned GAP_CYC_DEF      = CLK_HZ / 2;      // 0.5 s
  localparam int unsigned TW_DEF           = 30;

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: 2-flop synchroniser, counter debouncer and a one-cycle
// press pulse on the debounced 1->0 edge. Release produces no pulse.
module key_debounce
  import music_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_lvl,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CntLast) begin
        lvl_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_lvl = lvl_q;
  assign press   = press_q;

endmodule

// File: rtl/music_ctrl.sv
// Play controller for the melody generator: key/alarm start, key stop, auto-stop at
// song end and optional looping with a silent gap. All outputs are registered.
module music_ctrl
  import music_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned PLAY_CYC     = PLAY_CYC_DEF,
  parameter int unsigned GAP_CYC      = GAP_CYC_DEF,
  parameter int unsigned TW           = TW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  input  logic trig,
  input  logic loop_en,
  output logic music,
  output logic playing,
  output logic done
);

  localparam logic [TW-1:0] PlayLast = TW'(PLAY_CYC - 1);
  localparam logic [TW-1:0] GapLast  = TW'(GAP_CYC - 1);

  logic          press;
  logic          key_lvl_unused;
  music_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          music_q, playing_q, done_q, done_d;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .key_lvl (key_lvl_unused),
    .press   (press)
  );

  // A key stop takes priority over a timeout in the same cycle, so no done pulse then.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (press || trig) begin
          state_d = StPlay;
          timer_d = '0;
        end
      end
      StPlay: begin
        if (press) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q == PlayLast) begin
          done_d  = 1'b1;
          state_d = loop_en ? StGap : StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap: begin
        if (press) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q == GapLast) begin
          state_d = StPlay;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // Outputs follow next-state so they switch together with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      music_q   <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      music_q   <= (state_d == StPlay);
      playing_q <= (state_d != StIdle);
      done_q    <= done_d;
    end
  end

  assign music   = music_q;
  assign playing = playing_q;
  assign done    = done_q;

endmodule

// File: tb/tb_music_ctrl.sv
// Self-checking bench for music_ctrl: directed scenarios plus random key/trig/loop traffic,
// all checked every cycle against a behavioural model of the play controller.
module tb_music_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned PLAY = 20;
  localparam int unsigned GAP  = 5;

  logic clk = 1'b0;
  logic rst_n, key_n, trig, loop_en;
  logic music, playing, done;

  always #5 clk = ~clk;

  music_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .PLAY_CYC     (PLAY),
    .GAP_CYC      (GAP),
    .TW           (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .trig    (trig),
    .loop_en (loop_en),
    .music   (music),
    .playing (playing),
    .done    (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = stopped, 1 = song sounding, 2 = silent gap.
  // m_elapsed counts cycles spent in the current mode, starting at 1.
  int m_mode, m_elapsed;
  bit m_lvl, m_press, m_done;
  bit raw_q[$];
  bit win[$];

  task automatic model_reset();
    m_mode    = 0;
    m_elapsed = 0;
    m_lvl     = 1'b1;
    m_press   = 1'b0;
    m_done    = 1'b0;
    raw_q     = {1'b1, 1'b1};
    win       = {};
  endtask

  task automatic model_edge();
    bit s2, pr, all_diff;
    s2 = raw_q.pop_front();
    raw_q.push_back(key_n);
    win.push_back(s2);
    if (win.size() > DEB) void'(win.pop_front());
    pr      = m_press;
    m_press = 1'b0;
    // Accepted level flips once the last DEB synchronised samples all disagree with it.
    if (win.size() == DEB) begin
      all_diff = 1'b1;
      foreach (win[i]) if (win[i] == m_lvl) all_diff = 1'b0;
      if (all_diff) begin
        if (m_lvl) m_press = 1'b1;
        m_lvl = ~m_lvl;
        win.delete();
      end
    end
    m_done = 1'b0;
    case (m_mode)
      0: if (pr || trig) begin m_mode = 1; m_elapsed = 1; end
      1: begin
        if (pr) m_mode = 0;
        else if (m_elapsed == PLAY) begin
          m_done = 1'b1;
          m_mode = loop_en ? 2 : 0;
          m_elapsed = 1;
        end else m_elapsed++;
      end
      default: begin
        if (pr) m_mode = 0;
        else if (m_elapsed == GAP) begin m_mode = 1; m_elapsed = 1; end
        else m_elapsed++;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check("music", music, 32'(m_mode == 1));
    check("playing", playing, 32'(m_mode != 0));
    check("done", done, 32'(m_done));
  endtask

  task automatic run(input int n, output int hi, output int dn);
    hi = 0;
    dn = 0;
    repeat (n) begin
      step();
      if (music === 1'b1) hi++;
      if (done === 1'b1) dn++;
    end
  endtask

  initial begin
    int h, d, h1, d1, h2, d2, h3, d3, tot, lat;
    rst_n = 1'b0; key_n = 1'b1; trig = 1'b0; loop_en = 1'b0;
    model_reset();

    // Reset with a toggling key, then release.
    for (int i = 0; i < 3; i++) begin key_n = i[0]; step(); end
    key_n = 1'b1;
    rst_n = 1'b1;
    run(10, h, d);
    check("idle_after_reset", 32'(playing), 0);

    // Bouncing key must never start the song.
    tot = 0;
    repeat (5) begin
      key_n = 1'b0; run(3, h, d); tot += h;
      key_n = 1'b1; run(3, h, d); tot += h;
    end
    check("bounce_no_play", tot, 0);

    // Clean 6-cycle press: music rises 2+4+1 cycles after the falling edge.
    key_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 6) key_n = 1'b1;
      if (music === 1'b1 && lat == 0) lat = i;
    end
    check("press_latency", lat, 7);
    run(30, h, d);

    // Single run via trig with looping off.
    trig = 1'b1; run(1, h1, d1); trig = 1'b0;
    run(25, h, d);
    check("single_run_len", h + h1, PLAY);
    check("single_run_done", d, 1);
    check("idle_after_run", 32'(playing), 0);

    // Looping: play, gap, play, then a press lands in the second gap.
    loop_en = 1'b1;
    trig = 1'b1; run(1, h1, d1); trig = 1'b0;
    run(19, h, d);
    check("loop_play1", h + h1, PLAY);
    run(5, h, d);
    check("gap_quiet", h, 0);
    check("gap_playing", 32'(playing), 1);
    run(15, h1, d1);
    key_n = 1'b0; run(6, h, d); key_n = 1'b1;
    check("loop_play2", h + h1, PLAY);
    run(1, h, d);
    check("gap_stop", 32'(playing), 0);
    loop_en = 1'b0;
    run(10, h, d);

    // Press coincides with the timeout cycle: stop wins, no done.
    trig = 1'b1; run(1, h1, d1); trig = 1'b0;
    run(13, h, d);
    key_n = 1'b0; run(6, h2, d2); key_n = 1'b1;
    run(10, h3, d3);
    check("collision_no_done", d1 + d + d2 + d3, 0);
    check("collision_len", h1 + h + h2 + h3, PLAY);

    // trig while playing does not restart the song.
    trig = 1'b1; run(1, h1, d1); trig = 1'b0;
    run(5, h, d);
    trig = 1'b1; run(1, h2, d2); trig = 1'b0;
    run(20, h3, d3);
    check("trig_in_play_len", h1 + h + h2 + h3, PLAY);
    check("trig_in_play_done", d1 + d + d2 + d3, 1);

    // Asynchronous reset mid-song drops music before the next edge.
    trig = 1'b1; run(1, h1, d1); trig = 1'b0;
    run(10, h, d);
    rst_n = 1'b0;
    #1;
    check("async_music", 32'(music), 0);
    check("async_playing", 32'(playing), 0);
    run(3, h, d);
    rst_n = 1'b1;
    run(2, h, d);
    trig = 1'b1; run(1, h1, d1); trig = 1'b0;
    run(25, h, d);
    check("post_reset_len", h + h1, PLAY);
    check("post_reset_done", d + d1, 1);

    // Random traffic.
    for (int c = 0; c < 3000; ) begin
      int hold;
      hold = $urandom_range(1, 8);
      key_n = 1'($urandom_range(0, 1));
      repeat (hold) begin
        trig = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
        if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        c++;
      end
    end
    trig = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
